// File: rtl/pipeline_control_pkg.sv
// Shared codes for the pipeline controller: state encodings, sizing defaults,
// the per-stage control bundle and the hazard priority helper.
package pipeline_control_pkg;

  localparam int unsigned PC_DRAIN_CYCLES = 4;
  localparam int unsigned PC_CYCLE_W      = 32;
  localparam int unsigned PC_STATE_W      = 3;

`ifdef PIPELINE_CONTROL_STALL_COUNT_EN
  localparam int unsigned PC_STALL_W      = 16;
`endif

  typedef enum logic [PC_STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } pc_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_bubble;
    logic back_en;
  } pipe_ctrl_t;

  // Front-end controls for an executing cycle; HALT beats load-use beats branch.
  function automatic pipe_ctrl_t resolve_hazard(input logic halt,
                                                input logic load_hazard,
                                                input logic branch_taken);
    pipe_ctrl_t c;
    c         = '0;
    c.back_en = 1'b1;
    if (halt || load_hazard) begin
      c.id_ex_bubble = 1'b1;
    end else if (branch_taken) begin
      c.pc_en       = 1'b1;
      c.if_id_flush = 1'b1;
    end else begin
      c.pc_en    = 1'b1;
      c.if_id_en = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_drain_counter.sv
// Loadable down-counter that holds at zero; o_zero flags the terminal count.
module pipeline_drain_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero
);

  logic [WIDTH-1:0] count;

  // Load takes precedence; otherwise count down and stop at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count <= '0;
    end else if (i_load) begin
      count <= i_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign o_zero = (count == '0);

endmodule

// File: rtl/pipeline_control.sv
// Pipeline sequencing controller: IDLE/RUN/STEP/DRAIN/HALTED with same-cycle
// hazard resolution and an executed-cycle counter.
// Optional macro PIPELINE_CONTROL_STALL_COUNT_EN adds a saturating
// load-use stall counter on o_stall_count.
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = PC_DRAIN_CYCLES,
  parameter int unsigned CYCLE_W      = PC_CYCLE_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load_hazard,
  input  logic               i_halt,
  input  logic               i_branch_taken,
  input  logic               i_run,
  input  logic               i_step,
  output logic               o_pc_en,
  output logic               o_if_id_en,
  output logic               o_if_id_flush,
  output logic               o_id_ex_bubble,
  output logic               o_back_en,
  output logic               o_halted,
  output logic [CYCLE_W-1:0] o_cycles
`ifdef PIPELINE_CONTROL_STALL_COUNT_EN
  ,
  output logic [PC_STALL_W-1:0] o_stall_count
`endif
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  pc_state_e    state;
  pc_state_e    state_next;
  pipe_ctrl_t   ctrl;
  logic         drain_load;
  logic         drain_zero;
  logic [CYCLE_W-1:0] cycles;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and Mealy pipeline controls.
  always_comb begin
    state_next = state;
    ctrl       = '0;
    unique case (state)
      ST_IDLE: begin
        if (i_run) begin
          state_next = ST_RUN;
        end else if (i_step) begin
          state_next = ST_STEP;
        end
      end
      ST_RUN: begin
        ctrl = resolve_hazard(i_halt, i_load_hazard, i_branch_taken);
        if (i_halt) begin
          state_next = ST_DRAIN;
        end else if (!i_run) begin
          state_next = ST_IDLE;
        end
      end
      ST_STEP: begin
        ctrl       = resolve_hazard(i_halt, i_load_hazard, i_branch_taken);
        state_next = i_halt ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        ctrl.id_ex_bubble = 1'b1;
        ctrl.back_en      = 1'b1;
        if (drain_zero) begin
          state_next = ST_HALTED;
        end
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Arm the drain count on the edge that enters DRAIN.
  assign drain_load = (state != ST_DRAIN) && (state_next == ST_DRAIN);

  pipeline_drain_counter #(
    .WIDTH (DRAIN_W)
  ) u_drain_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (drain_load),
    .i_value (DRAIN_W'(DRAIN_CYCLES - 1)),
    .o_zero  (drain_zero)
  );

  // Executed-cycle counter; wraps naturally.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cycles <= '0;
    end else if (ctrl.back_en) begin
      cycles <= cycles + CYCLE_W'(1);
    end
  end

`ifdef PIPELINE_CONTROL_STALL_COUNT_EN
  logic                  stall_cycle;
  logic [PC_STALL_W-1:0] stall_count;

  assign stall_cycle = ((state == ST_RUN) || (state == ST_STEP)) && !i_halt && i_load_hazard;

  // Saturating count of load-use stall cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_count <= '0;
    end else if (stall_cycle && (stall_count != '1)) begin
      stall_count <= stall_count + PC_STALL_W'(1);
    end
  end

  assign o_stall_count = stall_count;
`endif

  assign o_pc_en        = ctrl.pc_en;
  assign o_if_id_en     = ctrl.if_id_en;
  assign o_if_id_flush  = ctrl.if_id_flush;
  assign o_id_ex_bubble = ctrl.id_ex_bubble;
  assign o_back_en      = ctrl.back_en;
  assign o_halted       = (state == ST_HALTED);
  assign o_cycles       = cycles;

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: the driver pushes hand-written
// expectations per cycle, a negedge monitor pops and compares.
module tb_pipeline_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_hazard;
  logic        halt;
  logic        branch_taken;
  logic        run;
  logic        step;
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        back_en;
  logic        halted;
  logic [31:0] cycles;
`ifdef PIPELINE_CONTROL_STALL_COUNT_EN
  logic [15:0] stall_count;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        chk;
    logic [5:0]  ctl;
    logic [31:0] cyc;
    logic [15:0] stall;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_cyc   = '0;
  logic [15:0] exp_stall = '0;

  pipeline_control dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_load_hazard  (load_hazard),
    .i_halt         (halt),
    .i_branch_taken (branch_taken),
    .i_run          (run),
    .i_step         (step),
    .o_pc_en        (pc_en),
    .o_if_id_en     (if_id_en),
    .o_if_id_flush  (if_id_flush),
    .o_id_ex_bubble (id_ex_bubble),
    .o_back_en      (back_en),
    .o_halted       (halted),
    .o_cycles       (cycles)
`ifdef PIPELINE_CONTROL_STALL_COUNT_EN
    ,
    .o_stall_count  (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: every cycle's outputs are compared against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e   = sb.pop_front();
      act = {pc_en, if_id_en, if_id_flush, id_ex_bubble, back_en, halted};
      if (e.chk) begin
        total++;
        if (act !== e.ctl) begin
          bad++;
          $display("FAIL %s ctl: got %b want %b (pc,ifid,flush,bub,back,halted)", e.name, act, e.ctl);
        end
        total++;
        if (cycles !== e.cyc) begin
          bad++;
          $display("FAIL %s cycles: got %0d want %0d", e.name, cycles, e.cyc);
        end
`ifdef PIPELINE_CONTROL_STALL_COUNT_EN
        total++;
        if (stall_count !== e.stall) begin
          bad++;
          $display("FAIL %s stall_count: got %0d want %0d", e.name, stall_count, e.stall);
        end
`endif
      end
    end
  end

  // One cycle of stimulus; ctl = {pc_en, if_id_en, flush, bubble, back_en, halted}.
  task automatic cyc(input logic r, input logic ru, input logic st, input logic lh,
                     input logic br, input logic h, input logic chk,
                     input logic [5:0] ctl, input string name);
    exp_t e;
    rst = r; run = ru; step = st; load_hazard = lh; branch_taken = br; halt = h;
    e.chk   = chk;
    e.ctl   = ctl;
    e.cyc   = exp_cyc;
    e.stall = exp_stall;
    e.name  = name;
    sb.push_back(e);
    if (r) begin
      exp_cyc   = '0;
      exp_stall = '0;
    end else begin
      if (ctl[1]) exp_cyc = exp_cyc + 32'd1;
      if (lh && !h && ctl[1] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0;
    load_hazard = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    @(posedge clk);
    #1;
    //  rst run stp lh br  h  chk  ctl        name
    cyc(1, 0, 0, 0, 0, 0, 0, 6'b000000, "reset0");
    cyc(1, 0, 0, 0, 0, 0, 1, 6'b000000, "reset1");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b000000, "reset_idle");
    cyc(0, 1, 0, 0, 0, 0, 1, 6'b000000, "idle_to_run");
    cyc(0, 1, 0, 0, 0, 0, 1, 6'b110010, "run_plain");
    cyc(0, 1, 0, 1, 0, 0, 1, 6'b000110, "load_stall");
    cyc(0, 1, 0, 0, 0, 0, 1, 6'b110010, "after_stall");
    cyc(0, 1, 0, 1, 1, 0, 1, 6'b000110, "stall_beats_branch");
    cyc(0, 1, 0, 0, 1, 0, 1, 6'b101010, "branch_flush");
    cyc(0, 1, 0, 0, 0, 0, 1, 6'b110010, "run_plain2");
    cyc(0, 1, 0, 0, 0, 1, 1, 6'b000110, "halt_decode");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b000110, "drain1");
    cyc(0, 0, 1, 0, 0, 0, 1, 6'b000110, "drain2");
    cyc(0, 1, 0, 0, 0, 0, 1, 6'b000110, "drain3");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b000110, "drain4");
    cyc(0, 1, 1, 0, 0, 0, 1, 6'b000001, "halted1");
    cyc(0, 0, 1, 0, 0, 0, 1, 6'b000001, "halted_ignore_step");
    cyc(0, 1, 0, 0, 0, 0, 1, 6'b000001, "halted_ignore_run");
    cyc(1, 0, 0, 0, 0, 0, 1, 6'b000001, "halted_in_reset");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b000000, "reset_from_halted");
    cyc(0, 0, 1, 0, 0, 0, 1, 6'b000000, "step1_req");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b110010, "step1_exec");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b000000, "step1_idle");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b000000, "gap1");
    cyc(0, 0, 1, 0, 0, 0, 1, 6'b000000, "step2_req");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b110010, "step2_exec");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b000000, "gap2a");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b000000, "gap2b");
    cyc(0, 0, 1, 0, 0, 0, 1, 6'b000000, "step3_req");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b110010, "step3_exec");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b000000, "three_steps");
    cyc(0, 0, 1, 0, 0, 0, 1, 6'b000000, "step4_req");
    cyc(0, 0, 0, 0, 0, 1, 1, 6'b000110, "step_halt");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b000110, "drain_b1");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b000110, "drain_b2");
    cyc(1, 0, 0, 0, 0, 0, 1, 6'b000110, "reset_in_drain");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b000000, "idle_after_drain_reset");
    cyc(0, 1, 0, 0, 0, 0, 1, 6'b000000, "idle_to_run2");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b110010, "run_release");
    cyc(0, 0, 0, 0, 0, 0, 1, 6'b000000, "idle_after_release");

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_queue: got %0d entries left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Sequential controller for the five-stage MIPS pipeline. It sits between the hazard detection unit, the debug unit and the pipeline registers, and turns per-cycle hazard flags (load-use, taken branch, HALT decoded) into enable, flush and bubble controls. It sequences start-up, single-step execution, halt drain and the final halted state, and reports an executed-cycle count to the debug unit.

## Interface
- DRAIN_CYCLES, 4: cycles the back end (EX/MEM/WB) keeps running after HALT is decoded, so older instructions retire.
- CYCLE_W, 32: width of the executed-cycle counter.
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_load_hazard  in  1  load-use hazard from hazard detection; 1 = stall required.
- i_halt  in  1  HALT opcode present in IF/ID.
- i_branch_taken  in  1  branch/jump resolved taken in ID.
- i_run  in  1  debug unit requests continuous execution (level).
- i_step  in  1  debug unit single-step request (1-cycle pulse).
- o_pc_en  out  1  PC write enable.
- o_if_id_en  out  1  IF/ID register write enable.
- o_if_id_flush  out  1  IF/ID load NOP.
- o_id_ex_bubble  out  1  force control fields of ID/EX to NOP.
- o_back_en  out  1  enable for ID/EX, EX/MEM, MEM/WB and register-file writes.
- o_halted  out  1  pipeline fully drained after HALT.
- o_cycles  out  CYCLE_W  count of cycles with o_back_en = 1.

## Operation
- States: IDLE, RUN, STEP, DRAIN, HALTED. Encoding is 3 bits.
- IDLE: all enables 0, no flush or bubble. Goes to RUN if i_run = 1, else to STEP if i_step = 1. i_run has priority when both are set.
- RUN: o_back_en = 1. Goes to IDLE when i_run = 0. Goes to DRAIN on i_halt.
- STEP: exactly one enabled cycle, then IDLE. Goes to DRAIN instead if i_halt is set in that cycle.
- Hazard resolution applies in RUN and STEP. It is Mealy logic from the current inputs, in priority order:
  - i_halt: o_pc_en = 0, o_if_id_en = 0, o_id_ex_bubble = 1. HALT itself never enters ID/EX.
  - else i_load_hazard: o_pc_en = 0, o_if_id_en = 0, o_id_ex_bubble = 1 (one-cycle stall).
  - else i_branch_taken: o_pc_en = 1, o_if_id_flush = 1.
  - else: o_pc_en = 1, o_if_id_en = 1.
- Load hazard and taken branch in the same cycle: the stall wins. The branch is re-evaluated the next cycle, when it appears again.
- DRAIN:
  - Outputs: o_pc_en = 0, o_if_id_en = 0, o_id_ex_bubble = 1, o_back_en = 1.
  - The drain counter loads DRAIN_CYCLES-1 on entry and decrements each cycle.
  - Goes to HALTED when the counter reaches 0. DRAIN lasts exactly DRAIN_CYCLES cycles.
  - i_run and i_step are ignored in DRAIN.
- HALTED: all enables 0 and o_halted = 1. Only i_reset leaves HALTED.
- o_cycles increments on every cycle with o_back_en = 1. It wraps modulo 2^CYCLE_W.

## Timing
- Reset values: state IDLE, drain counter 0, o_cycles 0, every output 0.
- Reset mid-operation (in RUN, DRAIN or HALTED) returns to IDLE on the next edge and clears all counters.
- Enable, flush and bubble outputs are combinational from state and the same-cycle hazard inputs, with zero latency.
- o_halted is asserted the first cycle after the final DRAIN cycle.
- i_step pulse in IDLE: STEP follows on the next edge, giving exactly one cycle with o_back_en = 1.
- An i_step pulse that arrives while not in IDLE is dropped.
- From the HALT decode edge to o_halted = 1 takes DRAIN_CYCLES + 1 cycles.

## Configuration
- PIPELINE_CONTROL_STALL_COUNT_EN defined:
  - Adds output o_stall_count (16 bits, reset 0).
  - Increments once per load-hazard stall cycle in RUN or STEP.
  - Saturates at 16'hFFFF.
- PIPELINE_CONTROL_STALL_COUNT_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- State encodings and DRAIN_CYCLES default: localparams in the shared codes header, next to the opcode codes.
- Sub-module pipeline_drain_counter: loadable down-counter with a zero flag. Parameter is its width; ports are i_clk, i_reset, i_load, i_value, o_zero.

## Test plan
- Reset asserted for 2 cycles, then released with i_run = 0 -> all outputs 0, state IDLE, o_cycles = 0.
- i_run = 1, i_load_hazard pulsed for 1 cycle -> exactly that cycle has o_pc_en = 0, o_if_id_en = 0, o_id_ex_bubble = 1. The next cycle returns to pc_en = 1.
- i_load_hazard = 1 and i_branch_taken = 1 together -> o_if_id_flush = 0 and stall outputs set. The following cycle with only the branch set -> o_if_id_flush = 1.
- i_run = 1, i_halt at cycle N, DRAIN_CYCLES = 4:
  - o_back_en = 1 through cycles N+1..N+4.
  - o_halted = 1 from N+5.
  - Toggling i_run or i_step afterwards has no effect.
- From IDLE, three i_step pulses spaced 3 cycles apart -> exactly 3 cycles with o_back_en = 1, and o_cycles = 3.
- Reset asserted during DRAIN -> IDLE on the next edge, o_halted = 0, o_cycles = 0. With the macro defined, also o_stall_count = 0.
